// File: rtl/fft8_seq_ctrl.sv
// fft8_seq_ctrl: top-level sequencer for the 8-point FFT.
// Loads N_POINTS ROM samples into packed butterfly inputs, then walks STAGES
// butterfly stages over a start/done handshake and pulses o_done at the end.
// Optional WAIT-state timeout: define FFT_SEQ_CTRL_TIMEOUT_EN.
module fft8_seq_ctrl #(
    parameter int unsigned N_POINTS    = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned ROM_LAT     = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    output logic                    o_rom_en,
    output logic [ADDR_W-1:0]       o_rom_addr,
    input  logic [15:0]             i_rom_data,
    output logic [32*N_POINTS-1:0]  o_samples,
    output logic                    o_load_rdy,
    output logic                    o_stage_start,
    output logic [1:0]              o_stage_idx,
    input  logic                    i_stage_done,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(N_POINTS - 1);
    localparam logic [1:0]        LastStage = 2'(STAGES - 1);

    state_e                        r_state, w_state_d;
    logic                          r_rom_en, w_rom_en_d;
    logic [ADDR_W-1:0]             r_rom_addr, w_rom_addr_d;
    logic [32*N_POINTS-1:0]        r_samples, w_samples_d;
    logic                          r_load_rdy, w_load_rdy_d;
    logic                          r_stage_start, w_stage_start_d;
    logic [1:0]                    r_stage_idx, w_stage_idx_d;
    logic                          r_busy, w_busy_d;
    logic                          r_done, w_done_d;
    // Valid/address tags travelling alongside the ROM read latency.
    logic [ROM_LAT:0]              r_vld, w_vld_d;
    logic [ROM_LAT:0][ADDR_W-1:0]  r_tag, w_tag_d;
    logic                          w_issue;
    logic                          w_cap;
    logic                          w_unused;

`ifdef FFT_SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0]               r_tmo_cnt, w_tmo_cnt_d;
    logic                          r_err, w_err_d;
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    // Upper ROM byte is discarded by the capture format.
    assign w_unused = ^{i_rom_data[15:8], (TIMEOUT_CYC != 0)};

    assign w_cap = (r_state == StLoad) && r_vld[ROM_LAT];

    // Next-state, address sequencing, sample capture and stage handshake.
    always_comb begin
        w_state_d       = r_state;
        w_rom_en_d      = r_rom_en;
        w_rom_addr_d    = r_rom_addr;
        w_samples_d     = r_samples;
        w_load_rdy_d    = 1'b0;
        w_stage_start_d = 1'b0;
        w_stage_idx_d   = r_stage_idx;
        w_busy_d        = r_busy;
        w_done_d        = 1'b0;
        w_issue         = 1'b0;
`ifdef FFT_SEQ_CTRL_TIMEOUT_EN
        w_tmo_cnt_d     = r_tmo_cnt;
        w_err_d         = r_err;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d    = StLoad;
                    w_rom_en_d   = 1'b1;
                    w_rom_addr_d = '0;
                    w_busy_d     = 1'b1;
                    w_issue      = 1'b1;
                end
            end
            StLoad: begin
                if (r_rom_addr != LastAddr) begin
                    w_rom_addr_d = r_rom_addr + 1'b1;
                    w_issue      = 1'b1;
                end
                if (w_cap) begin
                    for (int k = 0; k < int'(N_POINTS); k++) begin
                        if (r_tag[ROM_LAT] == ADDR_W'(k)) begin
                            w_samples_d[32*k +: 32] = {16'b0, i_rom_data[7:0], 8'b0};
                        end
                    end
                    if (r_tag[ROM_LAT] == LastAddr) begin
                        w_rom_en_d      = 1'b0;
                        w_load_rdy_d    = 1'b1;
                        w_stage_start_d = 1'b1;
                        w_stage_idx_d   = 2'd0;
                        w_state_d       = StWait;
`ifdef FFT_SEQ_CTRL_TIMEOUT_EN
                        w_tmo_cnt_d     = '0;
`endif
                    end
                end
            end
            StWait: begin
                // A done coinciding with our own stage_start belongs to the previous stage.
                if (i_stage_done && !r_stage_start) begin
                    if (r_stage_idx == LastStage) begin
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                        w_state_d = StIdle;
                    end else begin
                        w_stage_idx_d   = r_stage_idx + 2'd1;
                        w_stage_start_d = 1'b1;
`ifdef FFT_SEQ_CTRL_TIMEOUT_EN
                        w_tmo_cnt_d     = '0;
`endif
                    end
                end
`ifdef FFT_SEQ_CTRL_TIMEOUT_EN
                else if (r_tmo_cnt == TmoW'(TIMEOUT_CYC - 1)) begin
                    w_err_d   = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = StIdle;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt + 1'b1;
                end
`endif
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Read-tag pipeline: a tag pushed with an address reaches the top ROM_LAT edges later.
    always_comb begin
        w_vld_d    = '0;
        w_tag_d    = '0;
        w_vld_d[0] = w_issue;
        w_tag_d[0] = w_rom_addr_d;
        for (int i = 1; i <= int'(ROM_LAT); i++) begin
            w_vld_d[i] = r_vld[i-1];
            w_tag_d[i] = r_tag[i-1];
        end
    end

    // State and registered outputs; reset clears everything, dropping in-flight reads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_rom_en      <= 1'b0;
            r_rom_addr    <= '0;
            r_samples     <= '0;
            r_load_rdy    <= 1'b0;
            r_stage_start <= 1'b0;
            r_stage_idx   <= 2'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_vld         <= '0;
            r_tag         <= '0;
`ifdef FFT_SEQ_CTRL_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_d;
            r_rom_en      <= w_rom_en_d;
            r_rom_addr    <= w_rom_addr_d;
            r_samples     <= w_samples_d;
            r_load_rdy    <= w_load_rdy_d;
            r_stage_start <= w_stage_start_d;
            r_stage_idx   <= w_stage_idx_d;
            r_busy        <= w_busy_d;
            r_done        <= w_done_d;
            r_vld         <= w_vld_d;
            r_tag         <= w_tag_d;
`ifdef FFT_SEQ_CTRL_TIMEOUT_EN
            r_tmo_cnt     <= w_tmo_cnt_d;
            r_err         <= w_err_d;
`endif
        end
    end

    assign o_rom_en      = r_rom_en;
    assign o_rom_addr    = r_rom_addr;
    assign o_samples     = r_samples;
    assign o_load_rdy    = r_load_rdy;
    assign o_stage_start = r_stage_start;
    assign o_stage_idx   = r_stage_idx;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Directed bench for fft8_seq_ctrl: registered ROM returning 16'hA501+addr,
// cycle-exact expectations per edge (edge 0 = edge that samples start).
module tb_fft8_seq_ctrl;

    localparam int unsigned N_POINTS = 8;
    localparam int unsigned ADDR_W   = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   rom_en;
    logic [ADDR_W-1:0]      rom_addr;
    logic [15:0]            rom_data;
    logic [32*N_POINTS-1:0] samples;
    logic                   load_rdy;
    logic                   stage_start;
    logic [1:0]             stage_idx;
    logic                   stage_done;
    logic                   busy;
    logic                   done;
    logic                   err;

    int n_checks = 0;
    int n_errors = 0;
    bit g_err_exp = 1'b0;

    fft8_seq_ctrl #(
        .N_POINTS    (N_POINTS),
        .ADDR_W      (ADDR_W),
        .STAGES      (3),
        .ROM_LAT     (1),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .o_rom_en      (rom_en),
        .o_rom_addr    (rom_addr),
        .i_rom_data    (rom_data),
        .o_samples     (samples),
        .o_load_rdy    (load_rdy),
        .o_stage_start (stage_start),
        .o_stage_idx   (stage_idx),
        .i_stage_done  (stage_done),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    // One-cycle-latency ROM.
    always @(posedge clk) begin
        if (rom_en) rom_data <= 16'hA501 + 16'(rom_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transform from IDLE and checks every cycle after edges 0..19.
    task automatic run_transform(input bit restart, input bit hold_done, input string name);
        logic [5:0]  exp_ctl;
        logic [31:0] exp_slot;
        int          k;
        start      = 1'b1;
        stage_done = hold_done;
        tick();
        start = 1'b0;
        for (int n = 0; n <= 19; n++) begin
            // {rom_en, busy, load_rdy, stage_start, done, err}
            exp_ctl = {n <= 8, n <= 17, n == 9, (n == 9 || n == 12 || n == 15), n == 18,
                       g_err_exp};
            n_checks++;
            if ({rom_en, busy, load_rdy, stage_start, done, err} !== exp_ctl) begin
                n_errors++;
                $display("FAIL %s ctl n=%0d got %b exp %b (en,busy,ldrdy,sstart,done,err)",
                         name, n, {rom_en, busy, load_rdy, stage_start, done, err}, exp_ctl);
            end
            if (n <= 9) begin
                n_checks++;
                if (rom_addr !== ADDR_W'(n <= 7 ? n : 7)) begin
                    n_errors++;
                    $display("FAIL %s rom_addr n=%0d got %0d exp %0d", name, n, rom_addr,
                             (n <= 7 ? n : 7));
                end
            end
            if (n >= 9 && n <= 17) begin
                n_checks++;
                if (stage_idx !== 2'((n - 9) / 3)) begin
                    n_errors++;
                    $display("FAIL %s stage_idx n=%0d got %0d exp %0d", name, n, stage_idx,
                             (n - 9) / 3);
                end
            end
            if (n >= 2 && n <= 9) begin
                k        = n - 2;
                exp_slot = 32'(k + 1) << 8;
                n_checks++;
                if (samples[32*k +: 32] !== exp_slot) begin
                    n_errors++;
                    $display("FAIL %s slot%0d n=%0d got %h exp %h", name, k, n,
                             samples[32*k +: 32], exp_slot);
                end
            end
            if (n == 19) begin
                for (int s = 0; s < int'(N_POINTS); s++) begin
                    exp_slot = 32'(s + 1) << 8;
                    n_checks++;
                    if (samples[32*s +: 32] !== exp_slot) begin
                        n_errors++;
                        $display("FAIL %s hold slot%0d got %h exp %h", name, s,
                                 samples[32*s +: 32], exp_slot);
                    end
                end
            end
            start      = restart && (n == 2 || n == 11);
            stage_done = (hold_done && n <= 9) || n == 11 || n == 14 || n == 17;
            if (n < 19) tick();
        end
        start      = 1'b0;
        stage_done = 1'b0;
    endtask

    task automatic check_cleared(input string name);
        n_checks++;
        if ({rom_en, busy, load_rdy, stage_start, done, err} !== 6'b0 || rom_addr !== '0 ||
            stage_idx !== 2'd0 || samples !== '0) begin
            n_errors++;
            $display("FAIL %s cleared got ctl=%b addr=%0d idx=%0d samples=%h exp all zero",
                     name, {rom_en, busy, load_rdy, stage_start, done, err}, rom_addr,
                     stage_idx, samples);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b0;
        stage_done = 1'b0;
        tick();
        tick();
        check_cleared("reset");
        reset = 1'b0;
        tick();
        check_cleared("post_reset_idle");
    endtask

    task automatic test_basic();
        run_transform(1'b0, 1'b0, "basic");
    endtask

    task automatic test_back_to_back();
        run_transform(1'b1, 1'b0, "restart_ignored");
    endtask

    task automatic test_stage_done_hold();
        stage_done = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, stage_start, done} !== 3'b000) begin
            n_errors++;
            $display("FAIL idle_done_ignored got %b exp 000", {busy, stage_start, done});
        end
        run_transform(1'b0, 1'b1, "done_held");
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        reset = 1'b1;
        tick();
        check_cleared("reset_mid_load");
        reset = 1'b0;
        tick();
        tick();
        check_cleared("reset_mid_load_idle");
        run_transform(1'b0, 1'b0, "after_reset");
    endtask

`ifdef FFT_SEQ_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int seen_done = 0;
        start      = 1'b1;
        stage_done = 1'b0;
        tick();
        start = 1'b0;
        for (int n = 0; n <= 27; n++) begin
            if (done) seen_done++;
            if (n == 24 || n == 25) begin
                n_checks++;
                if ({err, busy} !== (n == 25 ? 2'b10 : 2'b01)) begin
                    n_errors++;
                    $display("FAIL timeout n=%0d got err,busy=%b exp %b", n, {err, busy},
                             (n == 25 ? 2'b10 : 2'b01));
                end
            end
            tick();
        end
        n_checks++;
        if (seen_done != 0) begin
            n_errors++;
            $display("FAIL timeout_no_done got %0d done pulses exp 0", seen_done);
        end
        g_err_exp = 1'b1;
        run_transform(1'b0, 1'b0, "after_timeout");
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stage_done = 1'b0;
        test_reset();
        test_basic();
        tick();
        test_back_to_back();
        tick();
        test_stage_done_hold();
        tick();
        test_reset_mid_load();
`ifdef FFT_SEQ_CTRL_TIMEOUT_EN
        tick();
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a hang anywhere in the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
